// File: rtl/nibble_rr_scheduler_if.sv
// nibble_rr_scheduler_if
// Bundles the requester-side inputs and the lane-side outputs of the
// nibble round-robin scheduler. The requesters and testbench use the
// master modport. The scheduler itself uses the slave modport.
interface nibble_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] data;
    logic              inv_mode;
    logic [NREQ-1:0]   grant;
    logic [W-1:0]      lane_out;
    logic              busy;
    logic              lane_par;

    modport master (
        output req, data, inv_mode,
        input  grant, lane_out, busy, lane_par
    );

    modport slave (
        input  req, data, inv_mode,
        output grant, lane_out, busy, lane_par
    );
endinterface

// File: rtl/nibble_rr_scheduler.sv
// nibble_rr_scheduler
// Shares one W-bit output lane between NREQ requesters in round-robin order.
// An owner keeps the lane for at most HOLD cycles. It gives the lane up early
// when it drops its request. Every change of ownership passes through a
// one-cycle dead gap. The lane carries the owner's nibble, and this value is
// optionally inverted to match the inverter-bank polarity.
// Optional feature: define NIBBLE_SCHED_PARITY_EN to register even parity of
// the lane on lane_par. Without the macro, lane_par is tied to 0.
module nibble_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int HOLD = 4
) (
    input logic                  clk,
    input logic                  reset,
    nibble_rr_scheduler_if.slave bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   owner;
    logic [IDXW-1:0]   ptr;
    logic [CNTW-1:0]   cnt;
    logic [NREQ-1:0]   grant_q;
    logic [W-1:0]      lane_q;
    logic              busy_q;

    logic              any_req;
    logic [IDXW-1:0]   arb_idx;
    logic [IDXW-1:0]   scan_idx;
    logic [W-1:0]      inv_mask;
    logic [W-1:0]      arb_lane;
    logic [W-1:0]      own_lane;
    logic              release_now;
    logic [W-1:0]      lane_nxt;

    // Round-robin pick, owner release decision and next lane value.
    // The scan runs from the far end back toward ptr, so the requester
    // closest to ptr is written last and wins.
    always_comb begin
        any_req  = |bus.req;
        arb_idx  = '0;
        scan_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            scan_idx = IDXW'((int'(ptr) + i) % NREQ);
            if (bus.req[scan_idx]) begin
                arb_idx = scan_idx;
            end
        end
        inv_mask    = {W{bus.inv_mode}};
        arb_lane    = bus.data[int'(arb_idx) * W +: W] ^ inv_mask;
        own_lane    = bus.data[int'(owner) * W +: W] ^ inv_mask;
        release_now = !bus.req[owner] || (cnt == '0);
        lane_nxt    = '0;
        case (state)
            GRANT:   lane_nxt = release_now ? '0 : own_lane;
            default: lane_nxt = any_req ? arb_lane : '0;
        endcase
    end

    // Ownership FSM. It keeps all outputs registered. IDLE and GAP both
    // arbitrate on their edge, so GAP lasts exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            cnt     <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            lane_q  <= '0;
        end else begin
            lane_q <= lane_nxt;
            case (state)
                IDLE, GAP: begin
                    if (any_req) begin
                        state   <= GRANT;
                        owner   <= arb_idx;
                        grant_q <= NREQ'(1) << arb_idx;
                        busy_q  <= 1'b1;
                        cnt     <= CNTW'(HOLD - 1);
                    end else begin
                        state   <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state   <= GAP;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr     <= (owner == IDXW'(NREQ - 1)) ? '0 : owner + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.lane_out = lane_q;
    assign bus.busy     = busy_q;

`ifdef NIBBLE_SCHED_PARITY_EN
    logic par_q;

    // Parity is captured on the same edge as the lane. It therefore always
    // matches the nibble currently on lane_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^lane_nxt;
        end
    end

    assign bus.lane_par = par_q;
`else
    assign bus.lane_par = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_rr_scheduler.sv
// tb_nibble_rr_scheduler
// This bench first runs directed scenarios against hand-computed values.
// It then applies randomized requests, data, polarity and asynchronous resets.
// On every falling edge, the outputs are compared with a behavioural
// owner/rotation model.
// The bench honours NIBBLE_SCHED_PARITY_EN for the lane_par expectation.
module tb_nibble_rr_scheduler;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int HOLD = 4;

    logic clk;
    logic reset;
    logic cmp_en;
    int   total;
    int   bad;

    nibble_rr_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

    nibble_rr_scheduler #(.NREQ(NREQ), .W(W), .HOLD(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The model tracks who owns the lane, for how many cycles it has owned it,
    // and where the next search starts. An owner of -1 means no owner.
    typedef struct packed {
        int           owner;
        int           held;
        int           ptr;
        logic [W-1:0] lane;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t cur, logic [NREQ-1:0] r,
                                          logic [NREQ*W-1:0] d, logic inv);
        model_t nx;
        int     cand;
        nx = cur;
        if (cur.owner >= 0) begin
            if (r[cur.owner] == 1'b0 || cur.held >= HOLD) begin
                nx.owner = -1;
                nx.held  = 0;
                nx.ptr   = (cur.owner + 1) % NREQ;
                nx.lane  = '0;
            end else begin
                nx.held = cur.held + 1;
                nx.lane = d[cur.owner * W +: W] ^ {W{inv}};
            end
        end else begin
            nx.owner = -1;
            nx.lane  = '0;
            for (int i = 0; i < NREQ; i++) begin
                cand = (cur.ptr + i) % NREQ;
                if (nx.owner < 0 && r[cand]) nx.owner = cand;
            end
            if (nx.owner >= 0) begin
                nx.held = 1;
                nx.lane = d[nx.owner * W +: W] ^ {W{inv}};
            end
        end
        return nx;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '{owner: -1, held: 0, ptr: 0, lane: '0};
        else       m <= model_step(m, bus.req, bus.data, bus.inv_mode);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // On every falling edge, the outputs are compared with the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic exp_par;
`ifdef NIBBLE_SCHED_PARITY_EN
            exp_par = ^m.lane;
`else
            exp_par = 1'b0;
`endif
            checkOutput("model_grant", 32'(bus.grant),
                        (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0);
            checkOutput("model_lane", 32'(bus.lane_out), 32'(m.lane));
            checkOutput("model_busy", 32'(bus.busy), (m.owner >= 0) ? 32'd1 : 32'd0);
            checkOutput("model_par", 32'(bus.lane_par), 32'(exp_par));
        end
    end

    // This task must be called at a falling edge. It drives the inputs, and
    // after the next rising edge it returns at the following falling edge.
    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*W-1:0] d,
                                 input logic inv);
        bus.req      = r;
        bus.data     = d;
        bus.inv_mode = inv;
        @(negedge clk);
    endtask

    task automatic doReset();
        bus.req = '0;
        reset   = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_grant"}, 32'(bus.grant), 32'd0);
        checkOutput({name, "_lane"}, 32'(bus.lane_out), 32'd0);
        checkOutput({name, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    logic [NREQ-1:0]   exp_grants [NREQ];
    logic [W-1:0]      exp_lanes  [NREQ];
    logic [NREQ-1:0]   r_rand;
    logic [NREQ*W-1:0] d_rand;
    logic              inv_rand;
    logic              exp_par7;

    initial begin
        total        = 0;
        bad          = 0;
        cmp_en       = 1'b0;
        reset        = 1'b1;
        bus.req      = '0;
        bus.data     = '0;
        bus.inv_mode = 1'b0;
        exp_grants   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_lanes    = '{4'hE, 4'hD, 4'hC, 4'hB};
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;
        checkIdle("reset");
        checkOutput("reset_par", 32'(bus.lane_par), 32'd0);

        // The lane stays idle when nobody requests it.
        for (int i = 0; i < 5; i++) begin
            applyStimulus('0, '0, 1'b0);
            checkIdle("idle");
        end

        // A sole requester owns the lane for HOLD cycles, then a gap follows, then it is re-granted.
        for (int c = 0; c < HOLD; c++) begin
            applyStimulus(4'b0001, 16'h000A, 1'b0);
            checkOutput("sole_grant", 32'(bus.grant), 32'h1);
            checkOutput("sole_lane", 32'(bus.lane_out), 32'hA);
        end
        applyStimulus(4'b0001, 16'h000A, 1'b0);
        checkIdle("sole_gap");
        applyStimulus(4'b0001, 16'h000A, 1'b0);
        checkOutput("sole_regrant", 32'(bus.grant), 32'h1);

        // All requesters are active with inverted data. The owners rotate 0,1,2,3,0.
        doReset();
        for (int k = 0; k <= NREQ; k++) begin
            for (int c = 0; c < HOLD; c++) begin
                applyStimulus(4'b1111, 16'h4321, 1'b1);
                checkOutput("rr_grant", 32'(bus.grant), 32'(exp_grants[k % NREQ]));
                checkOutput("rr_lane", 32'(bus.lane_out), 32'(exp_lanes[k % NREQ]));
            end
            applyStimulus(4'b1111, 16'h4321, 1'b1);
            checkIdle("rr_gap");
        end

        // Owner 2 releases early, so ptr moves to 3 and the scan 3,0 picks requester 0.
        doReset();
        applyStimulus(4'b0100, 16'h5555, 1'b0);
        checkOutput("early_g1", 32'(bus.grant), 32'h4);
        applyStimulus(4'b0100, 16'h5555, 1'b0);
        checkOutput("early_g2", 32'(bus.grant), 32'h4);
        applyStimulus(4'b0011, 16'h5555, 1'b0);
        checkIdle("early_gap");
        applyStimulus(4'b0011, 16'h5555, 1'b0);
        checkOutput("early_next", 32'(bus.grant), 32'h1);

        // Move ptr to 1. Then reset asynchronously in the middle of a grant, and check that ptr returns to 0.
        doReset();
        applyStimulus(4'b0001, 16'h1234, 1'b0);
        applyStimulus(4'b0100, 16'h1234, 1'b0);
        applyStimulus(4'b0100, 16'h1234, 1'b0);
        checkOutput("pre_rst_grant", 32'(bus.grant), 32'h4);
        #3 reset = 1'b1;
        #1 checkIdle("async_rst");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'b0101, 16'h1234, 1'b0);
        checkOutput("post_rst_grant", 32'(bus.grant), 32'h1);

        // This test checks parity of the nibble 7.
        doReset();
        applyStimulus(4'b0001, 16'h0007, 1'b0);
        checkOutput("par_lane", 32'(bus.lane_out), 32'h7);
`ifdef NIBBLE_SCHED_PARITY_EN
        exp_par7 = 1'b1;
`else
        exp_par7 = 1'b0;
`endif
        checkOutput("par_bit", 32'(bus.lane_par), 32'(exp_par7));

        // Randomized traffic with occasional asynchronous resets.
        r_rand   = '0;
        inv_rand = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 5) == 0) r_rand = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) inv_rand = ~inv_rand;
            d_rand = (NREQ*W)'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                bus.req      = r_rand;
                bus.data     = d_rand;
                bus.inv_mode = inv_rand;
                if ($urandom_range(0, 1) == 0) #($urandom_range(1, 4));
                else                           #($urandom_range(6, 9));
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                applyStimulus(r_rand, d_rand, inv_rand);
            end
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
